zp_sub_arbiter: RTL

Shares one registered zero-point subtraction stage between two int4 requesters: channel 0 carries activations and channel 1 carries weights. Each channel has its own programmable zero point. Grants alternate round-robin, and each result is tagged with its source channel. The block sits between the quantized input buffers and the multiply stage. It produces the (q - z) operands so the downstream multiplier works on pure integers.

---
 rtl/quant_pkg.sv | 12 +
 rtl/zp_sub_stage.sv | 59 +++++
 rtl/zp_sub_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared quantization constants and types for the int4 datapath.
package quant_pkg;

    localparam int QDW = 4;

    localparam logic CH_ACT = 1'b0;
    localparam logic CH_WGT = 1'b1;

    typedef logic signed [QDW-1:0] qdata_t;
    typedef logic signed [QDW:0]   qdiff_t;

endpackage

// File: rtl/zp_sub_stage.sv
// Registered zero-point subtraction (d - zp) with channel and frame-last sideband bits.
module zp_sub_stage #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] zp,
    input  logic          in_ch,
    input  logic          in_last,
    output logic          out_valid,
    output logic [DW:0]   out_data,
    output logic          out_ch,
    output logic          out_last
);

    logic          valid_q, valid_d;
    logic [DW:0]   data_q, data_d;
    logic          ch_q, ch_d;
    logic          last_q, last_d;

    // Sign-extend by one bit before subtracting so the result can never wrap.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        if (en) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = {d[DW-1], d} - {zp[DW-1], zp};
                ch_d   = in_ch;
                last_d = in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_last  = last_q;

endmodule

// File: rtl/zp_sub_arbiter.sv
// Round-robin arbiter sharing one zero-point subtraction stage between the
// activation (ch 0) and weight (ch 1) int4 streams, with per-channel frame counters.
module zp_sub_arbiter
    import quant_pkg::*;
#(
    parameter int DW        = 4,
    parameter int FRAME_LEN = 16,
    parameter int CW        = $clog2(FRAME_LEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            zp_wr_en,
    input  logic            zp_wr_sel,
    input  logic [DW-1:0]   zp_wr_data,
    input  logic [1:0]      req_valid,
    input  logic [2*DW-1:0] req_data,
    output logic [1:0]      req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW:0]     out_data,
    output logic            out_ch,
    output logic            out_last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic [1:0][DW-1:0] zp_q, zp_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;

    logic               accept;
    logic [1:0]         grant;
    logic               sel;
    logic [DW-1:0]      sel_data;
    logic               sel_last;

    assign accept = !out_valid || out_ready;

    // Gating with rst_n keeps req_ready low while reset is held.
    always_comb begin
        grant = 2'b00;
        if (accept && rst_n) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant_q == CH_WGT) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1] ? CH_WGT : CH_ACT;
    assign sel_data  = sel ? req_data[2*DW-1:DW] : req_data[DW-1:0];
    assign sel_last  = (cnt_q[sel] == LAST_IDX);

    // A write lands at the edge, so a grant in the same cycle still sees the old zp.
    always_comb begin
        zp_d = zp_q;
        if (zp_wr_en) begin
            zp_d[zp_wr_sel] = zp_wr_data;
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        for (int k = 0; k < 2; k++) begin
            if (grant[k]) begin
                cnt_d[k] = (cnt_q[k] == LAST_IDX) ? '0 : cnt_q[k] + CW'(1);
            end
        end
        if (|grant) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zp_q         <= '0;
            cnt_q        <= '0;
            last_grant_q <= CH_WGT;
        end else begin
            zp_q         <= zp_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    zp_sub_stage #(
        .DW(DW)
    ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (accept),
        .in_valid (|grant),
        .d        (sel_data),
        .zp       (zp_q[sel]),
        .in_ch    (sel),
        .in_last  (sel_last),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_last (out_last)
    );

endmodule
